// File: rtl/feinv.sv
// feinv: field inversion sequencer for GF(2^255-19).
// Computes out = a_in^EXP using an external field multiplier (default EXP = p-2).
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset
//   start      : one-cycle request, a_in sampled with it
//   a_in[254:0]: operand to invert
//   busy       : operation in progress (low again in the done cycle)
//   done       : one-cycle pulse, out valid from this cycle
//   out[254:0] : result, held until the next accepted start completes
//   mul_start  : one-cycle request to the field multiplier
//   mul_a/b    : multiplier operands, held while a product is outstanding
//   mul_done   : multiplier completion pulse
//   mul_out    : multiplier product, valid with mul_done
module feinv #(
    parameter int                  EXP_BITS = 255,
    parameter logic [EXP_BITS-1:0] EXP      = ~255'd20,
    parameter int                  IDX_W    = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [254:0] a_in,
    output logic         busy,
    output logic         done,
    output logic [254:0] out,
    output logic         mul_start,
    output logic [254:0] mul_a,
    output logic [254:0] mul_b,
    input  logic         mul_done,
    input  logic [254:0] mul_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR_ISSUE,
        S_SQR_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_FINISH
    } state_t;

    // Exponent zero-padded to a power-of-two width so the bit index
    // counter selects it without a width mismatch.
    localparam int                PADW     = 1 << IDX_W;
    localparam logic [PADW-1:0]   EXP_PAD  = PADW'(EXP);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'((EXP_BITS >= 2) ? (EXP_BITS - 2) : 0);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [254:0]       r_base;
    logic [254:0]       r_acc;
    logic [254:0]       r_mul_a;
    logic [254:0]       r_mul_b;
    logic [254:0]       r_out;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [254:0]       w_base_nxt;
    logic [254:0]       w_acc_nxt;
    logic [254:0]       w_mul_a_nxt;
    logic [254:0]       w_mul_b_nxt;
    logic [254:0]       w_out_nxt;
    logic               w_exp_bit;
    logic               w_idx_zero;

    assign w_exp_bit  = EXP_PAD[r_idx];
    assign w_idx_zero = (r_idx == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_acc   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_base  <= w_base_nxt;
            r_acc   <= w_acc_nxt;
            r_mul_a <= w_mul_a_nxt;
            r_mul_b <= w_mul_b_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Operands and the result are loaded on the transition into the
    // state that presents them, so mul_a/mul_b are already valid in the
    // ISSUE cycle and out is valid in the FINISH (done) cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        w_acc_nxt   = r_acc;
        w_mul_a_nxt = r_mul_a;
        w_mul_b_nxt = r_mul_b;
        w_out_nxt   = r_out;

        unique case (r_state)
            S_IDLE, S_FINISH: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    // Top exponent bit is 1, so the accumulator starts at a.
                    w_base_nxt = a_in;
                    w_acc_nxt  = a_in;
                    if (EXP_BITS == 1) begin
                        w_out_nxt   = a_in;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_nxt   = LAST_IDX;
                        w_mul_a_nxt = a_in;
                        w_mul_b_nxt = a_in;
                        w_state_nxt = S_SQR_ISSUE;
                    end
                end
            end

            S_SQR_ISSUE: begin
                w_state_nxt = S_SQR_WAIT;
            end

            S_SQR_WAIT: begin
                if (mul_done) begin
                    w_acc_nxt = mul_out;
                    if (w_exp_bit) begin
                        w_mul_a_nxt = mul_out;
                        w_mul_b_nxt = r_base;
                        w_state_nxt = S_MUL_ISSUE;
                    end else if (w_idx_zero) begin
                        w_out_nxt   = mul_out;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_nxt   = r_idx - IDX_W'(1);
                        w_mul_a_nxt = mul_out;
                        w_mul_b_nxt = mul_out;
                        w_state_nxt = S_SQR_ISSUE;
                    end
                end
            end

            S_MUL_ISSUE: begin
                w_state_nxt = S_MUL_WAIT;
            end

            S_MUL_WAIT: begin
                if (mul_done) begin
                    w_acc_nxt = mul_out;
                    if (w_idx_zero) begin
                        w_out_nxt   = mul_out;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_nxt   = r_idx - IDX_W'(1);
                        w_mul_a_nxt = mul_out;
                        w_mul_b_nxt = mul_out;
                        w_state_nxt = S_SQR_ISSUE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == S_SQR_ISSUE) || (r_state == S_SQR_WAIT) ||
                       (r_state == S_MUL_ISSUE) || (r_state == S_MUL_WAIT);
    assign done      = (r_state == S_FINISH);
    assign mul_start = (r_state == S_SQR_ISSUE) || (r_state == S_MUL_ISSUE);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out       = r_out;

endmodule

// File: tb/tb_feinv.sv
// tb_feinv: scoreboard bench for feinv with a behavioural field multiplier.
// Second instance uses a tiny exponent to check parameter overrides.
module tb_feinv;

    localparam logic [254:0] P    = ~255'd18;
    localparam logic [254:0] PM1  = ~255'd19;
    localparam logic [254:0] INV2 = (255'd1 << 254) - 255'd9;
    localparam logic [254:0] INV4 = (255'd3 << 253) - 255'd14;

    logic         clock;
    logic         reset;
    logic         start;
    logic [254:0] a_in;
    logic         busy;
    logic         done;
    logic [254:0] out;
    logic         mul_start;
    logic [254:0] mul_a;
    logic [254:0] mul_b;
    logic         mul_done;
    logic [254:0] mul_out;

    logic         start2;
    logic [254:0] a2;
    logic         busy2;
    logic         done2;
    logic [254:0] out2;
    logic         mul_start2;
    logic [254:0] mul_a2;
    logic [254:0] mul_b2;
    logic         mul_done2;
    logic [254:0] mul_out2;

    feinv dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_out   (mul_out)
    );

    feinv #(.EXP_BITS(2), .EXP(2'd3), .IDX_W(8)) dut2 (
        .clock     (clock),
        .reset     (reset),
        .start     (start2),
        .a_in      (a2),
        .busy      (busy2),
        .done      (done2),
        .out       (out2),
        .mul_start (mul_start2),
        .mul_a     (mul_a2),
        .mul_b     (mul_b2),
        .mul_done  (mul_done2),
        .mul_out   (mul_out2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [254:0] exp;
        int           scyc;
        int           lat;
        int           mbase;
        int           muls;
    } item_t;

    item_t q[$];
    item_t q2[$];

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;
    int lat     = 16;
    int nmul    = 0;
    int nmul2   = 0;
    int nstale  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] pr;
        logic [509:0] m;
        pr = {255'b0, a} * {255'b0, b};
        m  = pr % {255'b0, P};
        return m[254:0];
    endfunction

    // Multiplier model for the main instance; it deliberately ignores
    // reset so an abandoned product still delivers a stale done.
    logic         m_pend = 1'b0;
    int           m_cnt  = 0;
    logic [254:0] m_res;
    logic [254:0] cap_a;
    logic [254:0] cap_b;

    initial begin
        mul_done = 1'b0;
        mul_out  = '0;
    end

    always @(posedge clock) begin
        mul_done <= 1'b0;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                mul_done <= 1'b1;
                mul_out  <= m_res;
                m_pend = 1'b0;
                if (busy) begin
                    chk("mul_a_stable", mul_a, cap_a);
                    chk("mul_b_stable", mul_b, cap_b);
                end else begin
                    nstale++;
                end
            end
        end
        if (mul_start) begin
            chk("mul_overlap", {254'b0, m_pend}, '0);
            nmul++;
            m_res = fmul(mul_a, mul_b);
            cap_a = mul_a;
            cap_b = mul_b;
            if (lat <= 1) begin
                mul_done <= 1'b1;
                mul_out  <= m_res;
            end else begin
                m_pend = 1'b1;
                m_cnt  = lat - 1;
            end
        end
    end

    // Multiplier model for the override instance, fixed latency 16.
    logic         m2_pend = 1'b0;
    int           m2_cnt  = 0;
    logic [254:0] m2_res;

    initial begin
        mul_done2 = 1'b0;
        mul_out2  = '0;
    end

    always @(posedge clock) begin
        mul_done2 <= 1'b0;
        if (m2_pend) begin
            m2_cnt--;
            if (m2_cnt == 0) begin
                mul_done2 <= 1'b1;
                mul_out2  <= m2_res;
                m2_pend = 1'b0;
            end
        end
        if (mul_start2) begin
            nmul2++;
            m2_res  = fmul(mul_a2, mul_b2);
            m2_pend = 1'b1;
            m2_cnt  = 15;
        end
    end

    always @(negedge clock) begin
        item_t it;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 255'd1, 255'd0);
            end else begin
                it = q.pop_front();
                chk("out", out, it.exp);
                chk("busy_at_done", {254'b0, busy}, '0);
                chk("mul_count", 255'(nmul - it.mbase), 255'(it.muls));
                if (it.lat > 0)
                    chk("latency", 255'(cyc - it.scyc), 255'(it.lat));
            end
        end
    end

    always @(negedge clock) begin
        item_t it;
        if (done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 255'd1, 255'd0);
            end else begin
                it = q2.pop_front();
                chk("out2", out2, it.exp);
                chk("mul_count2", 255'(nmul2 - it.mbase), 255'(it.muls));
                chk("latency2", 255'(cyc - it.scyc), 255'(it.lat));
            end
        end
    end

    // Called at a negedge; start is held for exactly one cycle.
    task automatic issue(input logic [254:0] a, input logic [254:0] e, input int l);
        item_t it;
        start = 1'b1;
        a_in  = a;
        it.exp   = e;
        it.scyc  = cyc;
        it.lat   = l;
        it.mbase = nmul;
        it.muls  = 506;
        q.push_back(it);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", {254'b0, busy}, 255'd1);
    endtask

    task automatic wait_q(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (q.size() == 0 && q2.size() == 0) return;
            @(negedge clock);
        end
        chk("timeout_wait_done", 255'd1, 255'd0);
        q.delete();
        q2.delete();
    endtask

    task automatic wait_muls(input int base, input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (nmul - base >= n) return;
            @(negedge clock);
        end
        chk("timeout_wait_mul", 255'd1, 255'd0);
    endtask

    initial begin
        item_t it;
        int    b;
        logic  held_bad;

        reset  = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        start2 = 1'b0;
        a2     = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {254'b0, busy}, '0);
        chk("rst_done", {254'b0, done}, '0);
        chk("rst_mul_start", {254'b0, mul_start}, '0);
        chk("rst_out", out, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        reset = 1'b0;
        @(negedge clock);

        // a=1, full latency and pulse count
        issue(255'd1, 255'd1, 8603);
        wait_q(9000);

        // a=2 with a start pulse at operation 50 that must be ignored
        @(negedge clock);
        b = nmul;
        issue(255'd2, INV2, 8603);
        wait_muls(b, 50, 2000);
        start = 1'b1;
        a_in  = 255'd3;
        @(negedge clock);
        start = 1'b0;
        wait_q(9000);

        // a=0
        @(negedge clock);
        issue(255'd0, 255'd0, 8603);
        wait_q(9000);

        // p-1, then back-to-back start in its done cycle with a=4
        @(negedge clock);
        issue(PM1, PM1, 8603);
        for (int i = 0; i < 9000; i++) begin
            if (done) break;
            @(negedge clock);
        end
        chk("b2b_done_seen", {254'b0, done}, 255'd1);
        held_bad = 1'b0;
        issue(255'd4, INV4, 8603);
        for (int i = 0; i < 9000; i++) begin
            if (done) break;
            if (out !== PM1) held_bad = 1'b1;
            @(negedge clock);
        end
        chk("out_held", {254'b0, held_bad}, '0);
        wait_q(10);

        // short multiplier latency
        @(negedge clock);
        lat = 1;
        issue(255'd2, INV2, 1013);
        wait_q(1100);
        lat = 16;

        // reset in the middle of operation 100
        @(negedge clock);
        b = nmul;
        issue(255'd2, INV2, 0);
        wait_muls(b, 100, 3000);
        reset = 1'b1;
        q.delete();
        #1;
        chk("midrst_busy", {254'b0, busy}, '0);
        chk("midrst_mul_start", {254'b0, mul_start}, '0);
        chk("midrst_out", out, '0);
        @(negedge clock);
        reset = 1'b0;
        b = nmul;
        repeat (lat + 4) @(negedge clock);
        chk("stale_done_seen", 255'(nstale), 255'd1);
        chk("no_mul_after_rst", 255'(nmul - b), '0);
        chk("idle_after_rst", {254'b0, busy}, '0);
        issue(255'd2, INV2, 8603);
        wait_q(9000);

        // parameter override instance: 5^3
        @(negedge clock);
        start2   = 1'b1;
        a2       = 255'd5;
        it.exp   = 255'd125;
        it.scyc  = cyc;
        it.lat   = 35;
        it.mbase = nmul2;
        it.muls  = 2;
        q2.push_back(it);
        @(negedge clock);
        start2 = 1'b0;
        wait_q(200);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
